biriscv_inst_queue: RTL and testbench
=====================================

// Module: biriscv_inst_queue
// PURPOSE
//  Dual-issue instruction queue between the frontend decode outputs (fetch0/fetch1) and the issue stage.
//  - Decouples decode from issue stalls: up to 2 decoded instructions pushed and 2 popped per cycle, in program order.
//  - Flushed on any pipeline redirect.
// PARAMETERS
//  DEPTH    8  number of entries; power of two, >=4
//  DEPTH_W  3  log2(DEPTH)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   asynchronous active-low reset
//  flush_i           in   1   redirect (branch_request); discard all contents
//  in0_valid_i       in   1   older input instruction valid (from fetch0_*)
//  in0_entry_i       in   74  {pc[31:0],instr[31:0],fault_fetch,fault_page,exec,lsu,branch,mul,div,csr,rd_valid,invalid}
//  in0_accept_o      out  1   drives fetch0_accept_i
//  in1_valid_i       in   1   younger input instruction valid (from fetch1_*)
//  in1_entry_i       in   74  same layout as in0_entry_i
//  in1_accept_o      out  1   drives fetch1_accept_i
//  out0_valid_o      out  1   head entry valid
//  out0_entry_o      out  74  head entry
//  out0_accept_i     in   1   issue consumed head
//  out1_valid_o      out  1   head+1 entry valid
//  out1_entry_o      out  74  head+1 entry
//  out1_accept_i     in   1   issue consumed head+1 (honoured only with out0_accept_i)
//  level_o           out  DEPTH_W+1  current occupancy
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0, count=0; out*_valid_o=0, level_o=0, in0_accept_o=1, in1_accept_o=1; entries not cleared.
//  Accept (registered count only; no combinational path from out*_accept_i or in*_valid_i):
//   - in0_accept_o = (count <= DEPTH-1); in1_accept_o = (count <= DEPTH-2).
//   - A pop in the same cycle does not raise acceptance.
//  Push:
//   - push0 = in0_valid_i & in0_accept_o; push1 = in1_valid_i & in1_accept_o.
//   - Entries are written at wr_ptr in order in0 then in1.
//   - in1 alone (in0 invalid) writes at wr_ptr; wr_ptr advances by push0+push1.
//  Pop:
//   - pop0 = out0_valid_o & out0_accept_i; pop1 = pop0 & out1_valid_o & out1_accept_i.
//   - out1_accept_i without pop0 is ignored (no pop).
//   - rd_ptr advances by pop0+pop1.
//  Outputs:
//   - out0_valid_o = (count>=1); out1_valid_o = (count>=2).
//   - out*_entry_o are read combinationally from storage at rd_ptr, rd_ptr+1 (mod DEPTH).
//   - No empty bypass: push to out*_valid_o latency = 1 cycle.
//  count_next = count + pushes - pops (2-bit add/sub, DEPTH_W+1 wide); never exceeds DEPTH or underflows.
//  Pointers are DEPTH_W wide and wrap naturally at DEPTH; a dual push/pop straddling the wrap is legal.
//  flush_i:
//   - Next cycle: count=0, rd_ptr=wr_ptr=0.
//   - Same-cycle pushes and pops are discarded; out*_valid_o=0 from the next cycle.
//   - in*_accept_o stays as computed this cycle (the producer sees accept; the data is dropped).
//  Async reset mid-operation: immediate return to reset values; the queue restarts empty.
// CONFIGURATION
//  BIRISCV_IQ_PERF_EN defined:
//   - Adds outputs perf_full_cycles_o[31:0] (cycles with in0_valid_i & !in0_accept_o).
//   - Adds perf_flush_drop_o[31:0] (sum of count dropped at each flush_i).
//   - Both counters reset to 0 on rst_n, wrap modulo 2^32, and are not cleared by flush_i.
//  BIRISCV_IQ_PERF_EN undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared defines file (biriscv_defs.v):
//   - IQ_ENTRY_W=74 and field offsets IQ_PC_*, IQ_INSTR_*, IQ_FAULT_FETCH, IQ_FAULT_PAGE, IQ_EXEC .. IQ_INVALID.
//  Sub-module biriscv_iq_ram: DEPTH x IQ_ENTRY_W flop array.
//   - 2 write ports (wr0 at ptr, wr1 at ptr+k).
//   - 2 asynchronous read ports.
//   - No reset on data.
//  Top holds the pointers, count, accept/valid logic and optional perf counters.
// TESTING
//  1. Reset then idle.
//   - Expect out0/out1_valid_o=0, level_o=0, both accepts=1.
//  2. Dual push pc 0x80000000/0x80000004 with outputs held (no accept).
//   - Next cycle: level=2, out0.pc=0x80000000, out1.pc=0x80000004.
//  3. Fill to DEPTH, no pops.
//   - At count=7: in0_accept_o=1, in1_accept_o=0; only in0 is taken.
//   - At 8: both accepts=0; out*_accept_i=1 gives pop 2 and level=6 next cycle.
//  4. Steady state, 2 in + 2 out per cycle for 20 cycles across the pointer wrap.
//   - Output PC sequence strictly +4, no loss or duplication.
//  5. out1_accept_i=1 with out0_accept_i=0 at level=3.
//   - level stays 3 and the head is unchanged.
//  6. flush_i at level=5 with a simultaneous dual push.
//   - Next cycle: level=0, out*_valid_o=0.
//   - With PERF_EN: perf_flush_drop_o += 5.

Source files
------------

// File: rtl/biriscv_inst_queue_pkg.sv
// Shared definitions for the biRISC-V dual-issue instruction queue:
// entry width, field offsets of a decoded instruction entry, and an
// entry struct view with a PC accessor.
package biriscv_inst_queue_pkg;

    localparam int IQ_ENTRY_W     = 74;

    // Entry layout, MSB first:
    // {pc, instr, fault_fetch, fault_page, exec, lsu, branch, mul, div, csr, rd_valid, invalid}
    localparam int IQ_PC_HI       = 73;
    localparam int IQ_PC_LO       = 42;
    localparam int IQ_INSTR_HI    = 41;
    localparam int IQ_INSTR_LO    = 10;
    localparam int IQ_FAULT_FETCH = 9;
    localparam int IQ_FAULT_PAGE  = 8;
    localparam int IQ_EXEC        = 7;
    localparam int IQ_LSU         = 6;
    localparam int IQ_BRANCH      = 5;
    localparam int IQ_MUL         = 4;
    localparam int IQ_DIV         = 3;
    localparam int IQ_CSR         = 2;
    localparam int IQ_RD_VALID    = 1;
    localparam int IQ_INVALID     = 0;

    typedef logic [IQ_ENTRY_W-1:0] iq_word_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault_fetch;
        logic        fault_page;
        logic        exec;
        logic        lsu;
        logic        branch;
        logic        mul;
        logic        div;
        logic        csr;
        logic        rd_valid;
        logic        invalid;
    } iq_entry_t;

    // Extract the PC field of a flat entry word.
    function automatic logic [31:0] iq_pc(input iq_word_t e);
        return e[IQ_PC_HI:IQ_PC_LO];
    endfunction

endpackage

// File: rtl/biriscv_inst_queue_if.sv
// Handshake bundle of the instruction queue: two decode-side input lanes
// and two issue-side output lanes. The slave modport is the queue itself,
// the master modport is the surrounding pipeline (decode + issue).
interface biriscv_inst_queue_if
    import biriscv_inst_queue_pkg::*;
();

    logic     in0_valid_i;
    iq_word_t in0_entry_i;
    logic     in0_accept_o;
    logic     in1_valid_i;
    iq_word_t in1_entry_i;
    logic     in1_accept_o;

    logic     out0_valid_o;
    iq_word_t out0_entry_o;
    logic     out0_accept_i;
    logic     out1_valid_o;
    iq_word_t out1_entry_o;
    logic     out1_accept_i;

    modport slave (
        input  in0_valid_i, in0_entry_i, in1_valid_i, in1_entry_i,
        input  out0_accept_i, out1_accept_i,
        output in0_accept_o, in1_accept_o,
        output out0_valid_o, out0_entry_o, out1_valid_o, out1_entry_o
    );

    modport master (
        output in0_valid_i, in0_entry_i, in1_valid_i, in1_entry_i,
        output out0_accept_i, out1_accept_i,
        input  in0_accept_o, in1_accept_o,
        input  out0_valid_o, out0_entry_o, out1_valid_o, out1_entry_o
    );

endinterface

// File: rtl/biriscv_iq_ram.sv
// Instruction queue storage: DEPTH x IQ_ENTRY_W flop array with two write
// ports and two asynchronous read ports. Data is never reset; validity is
// tracked by the queue's count.
module biriscv_iq_ram
    import biriscv_inst_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic               clk,
    input  logic               wr0_en,
    input  logic [DEPTH_W-1:0] wr0_addr,
    input  iq_word_t           wr0_data,
    input  logic               wr1_en,
    input  logic [DEPTH_W-1:0] wr1_addr,
    input  iq_word_t           wr1_data,
    input  logic [DEPTH_W-1:0] rd0_addr,
    output iq_word_t           rd0_data,
    input  logic [DEPTH_W-1:0] rd1_addr,
    output iq_word_t           rd1_data
);

    iq_word_t mem [DEPTH];

    // Write both lanes; the top guarantees distinct addresses when both fire.
    always_ff @(posedge clk) begin
        if (wr0_en)
            mem[wr0_addr] <= wr0_data;
        if (wr1_en)
            mem[wr1_addr] <= wr1_data;
    end

    assign rd0_data = mem[rd0_addr];
    assign rd1_data = mem[rd1_addr];

endmodule

// File: rtl/biriscv_inst_queue.sv
// biRISC-V dual-issue instruction queue. Decouples decode from issue
// stalls: up to two entries pushed and two popped per cycle, in program
// order, emptied on any pipeline redirect (flush_i).
// Acceptance depends only on the registered count so there is no
// combinational path from the issue side back to decode.
// Optional build macro: BIRISCV_IQ_PERF_EN adds full-stall and
// flush-drop performance counters.
module biriscv_inst_queue
    import biriscv_inst_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    biriscv_inst_queue_if.slave  iq,
`ifdef BIRISCV_IQ_PERF_EN
    output logic [31:0]          perf_full_cycles_o,
    output logic [31:0]          perf_flush_drop_o,
`endif
    output logic [DEPTH_W:0]     level_o
);

    localparam logic [DEPTH_W:0] ROOM_FOR_1 = (DEPTH_W+1)'(DEPTH - 1);
    localparam logic [DEPTH_W:0] ROOM_FOR_2 = (DEPTH_W+1)'(DEPTH - 2);

    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0]   count_q,  count_d;

    logic       push0, push1, pop0, pop1;
    logic [1:0] push_cnt, pop_cnt;

    // Handshake terms, all derived from registered occupancy.
    assign iq.in0_accept_o = (count_q <= ROOM_FOR_1);
    assign iq.in1_accept_o = (count_q <= ROOM_FOR_2);
    assign iq.out0_valid_o = (count_q >= (DEPTH_W+1)'(1));
    assign iq.out1_valid_o = (count_q >= (DEPTH_W+1)'(2));

    assign push0    = iq.in0_valid_i & iq.in0_accept_o;
    assign push1    = iq.in1_valid_i & iq.in1_accept_o;
    assign pop0     = iq.out0_valid_o & iq.out0_accept_i;
    assign pop1     = pop0 & iq.out1_valid_o & iq.out1_accept_i;
    assign push_cnt = {1'b0, push0} + {1'b0, push1};
    assign pop_cnt  = {1'b0, pop0} + {1'b0, pop1};

    assign level_o  = count_q;

    // Next pointer/count; a flush discards everything including this cycle's traffic.
    always_comb begin
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pop_cnt);
        wr_ptr_d = wr_ptr_q + DEPTH_W'(push_cnt);
        count_d  = count_q + (DEPTH_W+1)'(push_cnt) - (DEPTH_W+1)'(pop_cnt);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // in1 lands right behind in0 when both push, or at wr_ptr when alone.
    biriscv_iq_ram #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk      (clk),
        .wr0_en   (push0 & ~flush_i),
        .wr0_addr (wr_ptr_q),
        .wr0_data (iq.in0_entry_i),
        .wr1_en   (push1 & ~flush_i),
        .wr1_addr (wr_ptr_q + DEPTH_W'(push0)),
        .wr1_data (iq.in1_entry_i),
        .rd0_addr (rd_ptr_q),
        .rd0_data (iq.out0_entry_o),
        .rd1_addr (rd_ptr_q + DEPTH_W'(1)),
        .rd1_data (iq.out1_entry_o)
    );

`ifdef BIRISCV_IQ_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_drop_q;

    // Stall and flush-loss counters; survive flushes, wrap modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_full_q <= '0;
            perf_drop_q <= '0;
        end else begin
            if (iq.in0_valid_i & ~iq.in0_accept_o)
                perf_full_q <= perf_full_q + 32'd1;
            if (flush_i)
                perf_drop_q <= perf_drop_q + 32'(count_q);
        end
    end

    assign perf_full_cycles_o = perf_full_q;
    assign perf_flush_drop_o  = perf_drop_q;
`endif

endmodule

// File: tb/tb_biriscv_inst_queue.sv
// Self-checking bench for biriscv_inst_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_biriscv_inst_queue;
    import biriscv_inst_queue_pkg::*;

    localparam int DEPTH   = 8;
    localparam int DEPTH_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [DEPTH_W:0] level;
`ifdef BIRISCV_IQ_PERF_EN
    logic [31:0]      perf_full;
    logic [31:0]      perf_drop;
`endif

    biriscv_inst_queue_if iq();

    biriscv_inst_queue #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush),
        .iq                 (iq),
`ifdef BIRISCV_IQ_PERF_EN
        .perf_full_cycles_o (perf_full),
        .perf_flush_drop_o  (perf_drop),
`endif
        .level_o            (level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    iq_word_t    mq[$];
    logic [31:0] next_pc;
    logic [31:0] exp_pop_pc;
    bit          pcseq_on;
    logic [31:0] m_full;
    logic [31:0] m_drop;

    task automatic chk(input string tag, input logic [73:0] got, input logic [73:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic iq_word_t mk_entry(input logic [31:0] pc);
        logic [9:0] flags;
        flags = 10'($urandom);
        return {pc, 32'($urandom), flags};
    endfunction

    // Compare every observable output against the model's view of the queue.
    task automatic check_state();
        int sz;
        sz = mq.size();
        chk("level",      74'(level),            74'(sz));
        chk("out0_valid", 74'(iq.out0_valid_o),  74'(sz >= 1));
        chk("out1_valid", 74'(iq.out1_valid_o),  74'(sz >= 2));
        chk("in0_accept", 74'(iq.in0_accept_o),  74'(sz <= DEPTH - 1));
        chk("in1_accept", 74'(iq.in1_accept_o),  74'(sz <= DEPTH - 2));
        if (sz >= 1) chk("out0_entry", iq.out0_entry_o, mq[0]);
        if (sz >= 2) chk("out1_entry", iq.out1_entry_o, mq[1]);
`ifdef BIRISCV_IQ_PERF_EN
        chk("perf_full", 74'(perf_full), 74'(m_full));
        chk("perf_drop", 74'(perf_drop), 74'(m_drop));
`endif
    endtask

    task automatic idle_inputs();
        iq.in0_valid_i   = 1'b0;
        iq.in1_valid_i   = 1'b0;
        iq.in0_entry_i   = '0;
        iq.in1_entry_i   = '0;
        iq.out0_accept_i = 1'b0;
        iq.out1_accept_i = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_full     = 32'd0;
        m_drop     = 32'd0;
        exp_pop_pc = next_pc;
    endtask

    // One clock: check at negedge, drive this cycle's inputs, advance the model at posedge.
    task automatic step(input bit v0, input bit v1, input bit a0, input bit a1, input bit fl);
        int       sz;
        bit       p0, p1, q0, q1;
        iq_word_t e0, e1;
        @(negedge clk);
        check_state();
        sz = mq.size();
        p0 = v0 && (sz <= DEPTH - 1);
        p1 = v1 && (sz <= DEPTH - 2);
        q0 = a0 && (sz >= 1);
        q1 = q0 && a1 && (sz >= 2);
        e0 = mk_entry(next_pc);
        e1 = mk_entry(next_pc + (p0 ? 32'd4 : 32'd0));
        if (pcseq_on && q0) chk("pc_seq0", 74'(iq_pc(iq.out0_entry_o)), 74'(exp_pop_pc));
        if (pcseq_on && q1) chk("pc_seq1", 74'(iq_pc(iq.out1_entry_o)), 74'(exp_pop_pc + 32'd4));
        iq.in0_valid_i   = v0;
        iq.in0_entry_i   = e0;
        iq.in1_valid_i   = v1;
        iq.in1_entry_i   = e1;
        iq.out0_accept_i = a0;
        iq.out1_accept_i = a1;
        flush            = fl;
        @(posedge clk);
        if (v0 && !(sz <= DEPTH - 1)) m_full = m_full + 32'd1;
        next_pc = next_pc + 32'd4 * (32'(p0) + 32'(p1));
        if (fl) begin
            m_drop = m_drop + 32'(sz);
            mq.delete();
            exp_pop_pc = next_pc;
        end else begin
            if (q0) begin void'(mq.pop_front()); exp_pop_pc = exp_pop_pc + 32'd4; end
            if (q1) begin void'(mq.pop_front()); exp_pop_pc = exp_pop_pc + 32'd4; end
            if (p0) mq.push_back(e0);
            if (p1) mq.push_back(e1);
        end
    endtask

    task automatic random_traffic(input int cycles);
        int pp, pa, pf;
        for (int i = 0; i < cycles; i++) begin
            if (i % 100 == 0) begin
                pp = $urandom_range(10, 95);
                pa = $urandom_range(10, 95);
                pf = $urandom_range(20, 80);
            end
            step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pp,
                 $urandom_range(0, 99) < pa, $urandom_range(0, 99) < pa,
                 $urandom_range(0, pf) == 0);
        end
    endtask

    iq_word_t    head;
    logic [31:0] drop_before;

    initial begin
        pcseq_on = 1'b0;
        next_pc  = 32'h0000_1000;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Dual push with outputs held
        next_pc    = 32'h8000_0000;
        exp_pop_pc = next_pc;
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        chk("t2_level", 74'(level), 74'd2);
        chk("t2_pc0", 74'(iq_pc(iq.out0_entry_o)), 74'(32'h8000_0000));
        chk("t2_pc1", 74'(iq_pc(iq.out1_entry_o)), 74'(32'h8000_0004));

        // Fill to DEPTH: 2 -> 3 -> 5 -> 7, then only in0 taken -> 8
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        #1;
        chk("t3_acc0_at7", 74'(iq.in0_accept_o), 74'd1);
        chk("t3_acc1_at7", 74'(iq.in1_accept_o), 74'd0);
        step(1, 1, 0, 0, 0);
        #1;
        chk("t3_level8", 74'(level), 74'd8);
        chk("t3_acc0_at8", 74'(iq.in0_accept_o), 74'd0);
        step(1, 1, 1, 1, 0);
        #1;
        chk("t3_level6", 74'(level), 74'd6);

        // Steady state 2 in / 2 out across the pointer wrap
        pcseq_on = 1'b1;
        repeat (20) step(1, 1, 1, 1, 0);
        pcseq_on = 1'b0;
        #1;
        chk("t4_level", 74'(level), 74'd6);

        // out1_accept without out0_accept is ignored
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        head = iq.out0_entry_o;
        step(0, 0, 0, 1, 0);
        #1;
        chk("t5_level", 74'(level), 74'd3);
        chk("t5_head", iq.out0_entry_o, head);

        // Flush at level 5 with simultaneous dual push
        step(1, 1, 0, 0, 0);
        drop_before = m_drop;
        step(1, 1, 0, 0, 1);
        #1;
        chk("t6_level", 74'(level), 74'd0);
        chk("t6_out0_valid", 74'(iq.out0_valid_o), 74'd0);
        chk("t6_drop_delta", 74'(m_drop - drop_before), 74'd5);
        step(0, 0, 0, 0, 0);

        // Randomized traffic
        random_traffic(1500);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("arst_level", 74'(level), 74'd0);
        chk("arst_out0_valid", 74'(iq.out0_valid_o), 74'd0);
        chk("arst_in1_accept", 74'(iq.in1_accept_o), 74'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        random_traffic(600);
        @(negedge clk);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
